// File: rtl/rf_wb_pkg.sv
// Shared widths, parameter defaults and the write-port request type for the
// register-file writeback arbiter.
package rf_wb_pkg;

    localparam int REG_ADDR_W          = 5;
    localparam int XLEN                = 32;
    localparam int NUM_REGS            = 32;
    localparam int MAX_OUTSTANDING_DEF = 4;
    localparam int STARVE_LIMIT_DEF    = 8;
    localparam int CNT_W               = 4;   // holds 0..15 outstanding ops
    localparam int STARVE_W            = 8;   // holds 0..255 blocked cycles

    typedef struct packed {
        logic                  wren;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for long-latency destinations: per-register pending
// bits, outstanding-op counter and the RAW/WAW/overflow hazard compare.
module rf_scoreboard
    import rf_wb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  set,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic                  clr_x0,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  is_lu,
    output logic                  hazard,
    output logic                  full
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [NUM_REGS-1:0] pending, pending_n;
    logic [CNT_W-1:0]    out_cnt, out_cnt_n;

    // NOTE: blocking assignments inside always_comb build the next value in
    // order, so the later set overrides an earlier clear of the same index.
    always_comb begin
        pending_n = pending;
        if (clr)
            pending_n[clr_addr] = 1'b0;
        if (set && set_addr != '0)
            pending_n[set_addr] = 1'b1;

        out_cnt_n = out_cnt;
        if (set)
            out_cnt_n = out_cnt_n + 1'b1;
        if (clr && out_cnt_n != '0)
            out_cnt_n = out_cnt_n - 1'b1;
        if (clr_x0 && out_cnt_n != '0)
            out_cnt_n = out_cnt_n - 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            pending <= '0;
            out_cnt <= '0;
        end else begin
            pending <= pending_n;
            out_cnt <= out_cnt_n;
        end
    end

    assign full   = (out_cnt == MAX_CNT);
    assign hazard = (rs1 != '0 && pending[rs1]) ||
                    (rs2 != '0 && pending[rs2]) ||
                    (rd  != '0 && pending[rd])  ||
                    (is_lu && full);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Single register-file write port shared between pipeline writeback (priority)
// and a one-entry skid for long-latency results, with issue-stall generation.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    parameter int STARVE_LIMIT    = STARVE_LIMIT_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_wb_wren,
    input  logic [REG_ADDR_W-1:0] i_wb_rd_addr,
    input  logic [XLEN-1:0]       i_wb_rd_data,
    input  logic                  i_lu_valid,
    output logic                  o_lu_ready,
    input  logic [REG_ADDR_W-1:0] i_lu_rd_addr,
    input  logic [XLEN-1:0]       i_lu_rd_data,
    input  logic                  i_issue_valid,
    input  logic                  i_issue_lu,
    input  logic [REG_ADDR_W-1:0] i_issue_rs1,
    input  logic [REG_ADDR_W-1:0] i_issue_rs2,
    input  logic [REG_ADDR_W-1:0] i_issue_rd,
    output logic                  o_stall,
    output logic                  o_rd_wren,
    output logic [REG_ADDR_W-1:0] o_rd_addr,
    output logic [XLEN-1:0]       o_rd_data
);

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic                  buf_valid;
    logic [REG_ADDR_W-1:0] buf_addr;
    logic [XLEN-1:0]       buf_data;
    logic [STARVE_W-1:0]   starve_cnt;

    logic    wb_grant, drain, accept, accept_x0, starve, issue_fire;
    logic    sb_hazard, sb_full;
    wb_req_t wr_req;

    // Every combinational output is gated by reset so the reset cycle is inert.
    assign wb_grant   = i_reset_n & i_wb_wren & (i_wb_rd_addr != '0);
    assign drain      = i_reset_n & buf_valid & ~wb_grant;
    assign o_lu_ready = i_reset_n & (~buf_valid | drain);
    assign accept     = i_lu_valid & o_lu_ready;
    assign accept_x0  = accept & (i_lu_rd_addr == '0);
    // starve_cnt > 0 implies buf_valid, so starvation ends in the drain cycle.
    assign starve     = (starve_cnt == STARVE_MAX) & ~drain;
    assign o_stall    = i_reset_n & ((i_issue_valid & sb_hazard) | starve);
    assign issue_fire = i_reset_n & i_issue_valid & i_issue_lu & ~o_stall;

    // NOTE: defaulting the struct first keeps this mux free of inferred latches.
    always_comb begin
        wr_req = '0;
        if (wb_grant) begin
            wr_req.wren = 1'b1;
            wr_req.addr = i_wb_rd_addr;
            wr_req.data = i_wb_rd_data;
        end else if (drain) begin
            wr_req.wren = 1'b1;
            wr_req.addr = buf_addr;
            wr_req.data = buf_data;
        end
    end

    assign o_rd_wren = wr_req.wren;
    assign o_rd_addr = wr_req.addr;
    assign o_rd_data = wr_req.data;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            buf_valid  <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if (accept && !accept_x0)
                buf_valid <= 1'b1;
            else if (drain)
                buf_valid <= 1'b0;

            if (!buf_valid || drain)
                starve_cnt <= '0;
            else if (wb_grant && starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // NOTE: the skid payload is qualified by buf_valid, so it needs no reset.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            buf_addr <= i_lu_rd_addr;
            buf_data <= i_lu_rd_data;
        end
    end

    rf_scoreboard #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_sb (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .set       (issue_fire),
        .set_addr  (i_issue_rd),
        .clr       (drain),
        .clr_addr  (buf_addr),
        .clr_x0    (accept_x0),
        .rs1       (i_issue_rs1),
        .rs2       (i_issue_rs2),
        .rd        (i_issue_rd),
        .is_lu     (i_issue_lu),
        .hazard    (sb_hazard),
        .full      (sb_full)
    );

endmodule
